// File: rtl/pic_8259_if.sv
// Bus and interrupt signals between the CPU-side bus controller and the pic_8259.
// Combinational read data (dout/dout_en); intr is registered inside the PIC.
// No backpressure: strobes are pulses and the PIC acts on their falling edges.
//
// Signals: cs_n/a0/rd_n/wr_n/din form the I/O register port. dout/dout_en return
// register or vector data. ir carries the eight request lines. inta_n is the
// acknowledge from the bus controller, and intr is the request to the CPU.
interface pic_8259_if;
    logic       cs_n;
    logic       a0;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_en;
    logic [7:0] ir;
    logic       inta_n;
    logic       intr;

    modport master (
        output cs_n, a0, rd_n, wr_n, din, ir, inta_n,
        input  dout, dout_en, intr
    );

    modport slave (
        input  cs_n, a0, rd_n, wr_n, din, ir, inta_n,
        output dout, dout_en, intr
    );
endinterface

// File: rtl/pic_8259.sv
// Simplified 8259A interrupt controller: single 8086 mode, edge requests, fixed priority.
// Latency: IRR is set 1 clk after an ir rising edge, and intr follows 1 clk later. Reads are combinational.
// No backpressure: write and inta strobes act on their sampled falling edges.
//
// Ports: clk and rst_n (async, active low). bus (pic_8259_if.slave) carries cs_n, a0, rd_n,
// wr_n, din, dout, dout_en, ir, inta_n and intr.
module pic_8259 #(
    parameter int NUM_IR       = 8,
    parameter int SPURIOUS_LVL = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    pic_8259_if.slave     bus
);

    typedef enum logic [1:0] {S_UNINIT, S_WAIT_ICW2, S_WAIT_ICW4, S_READY} init_t;
    typedef enum logic [1:0] {A_IDLE, A_ACK1, A_ACK2} ack_t;

    init_t      init_q, init_d;
    ack_t       ack_q, ack_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [4:0] base_q, base_d;
    logic       aeoi_q, aeoi_d;
    logic       rsel_q, rsel_d;
    logic       need_icw4_q, need_icw4_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic       wr_q, inta_q;
    logic [7:0] ir_q;
    logic       intr_q, intr_d;

    logic       wr_fall, inta_fall, inta_rise, is_icw1;
    logic [7:0] pending, prio_ok;
    logic       win_vld;
    logic [2:0] win_lvl, isr_top;
    logic       seen;
    logic       vec_out, rd_out;

    assign wr_fall   = wr_q & ~bus.wr_n & ~bus.cs_n;
    assign inta_fall = inta_q & ~bus.inta_n;
    assign inta_rise = ~inta_q & bus.inta_n;
    assign is_icw1   = wr_fall & ~bus.a0 & bus.din[4];
    assign pending   = irr_q & ~imr_q;
    assign win_vld   = |pending;

    // Winning request level, highest-priority in-service level, and the set of
    // levels that outrank every in-service level (no ISR bit at or below them).
    always_comb begin
        win_lvl = 3'(SPURIOUS_LVL);
        isr_top = 3'd0;
        prio_ok = 8'h00;
        seen    = 1'b0;
        for (int n = NUM_IR - 1; n >= 0; n--) begin
            if (pending[n]) win_lvl = 3'(n);
            if (isr_q[n])   isr_top = 3'(n);
        end
        for (int n = 0; n < NUM_IR; n++) begin
            seen       = seen | isr_q[n];
            prio_ok[n] = ~seen;
        end
    end

    assign intr_d = (init_q == S_READY) & |(pending & prio_ok);

    always_comb begin
        init_d      = init_q;
        ack_d       = ack_q;
        isr_d       = isr_q;
        imr_d       = imr_q;
        base_d      = base_q;
        aeoi_d      = aeoi_q;
        rsel_d      = rsel_q;
        need_icw4_d = need_icw4_q;
        lvl_d       = lvl_q;
        spur_d      = spur_q;
        // A request holds only while its line stays high; a new edge sets it.
        irr_d       = (irr_q | (bus.ir & ~ir_q)) & bus.ir;

        if (wr_fall) begin
            if (is_icw1) begin
                init_d      = S_WAIT_ICW2;
                need_icw4_d = bus.din[0];
                rsel_d      = 1'b0;
            end else begin
                case (init_q)
                    S_WAIT_ICW2: if (bus.a0) begin
                        base_d = bus.din[7:3];
                        init_d = need_icw4_q ? S_WAIT_ICW4 : S_READY;
                    end
                    S_WAIT_ICW4: if (bus.a0) begin
                        aeoi_d = bus.din[1];
                        init_d = S_READY;
                    end
                    S_READY: begin
                        if (bus.a0) begin
                            imr_d = bus.din;
                        end else if (bus.din[4:3] == 2'b00) begin
                            if (bus.din[7:5] == 3'b001)      isr_d[isr_top]     = 1'b0;
                            else if (bus.din[7:5] == 3'b011) isr_d[bus.din[2:0]] = 1'b0;
                        end else if (bus.din[4:3] == 2'b01) begin
                            if (bus.din[1]) rsel_d = bus.din[0];
                        end
                    end
                    default: ;
                endcase
            end
        end

        case (ack_q)
            A_IDLE: if (inta_fall) begin
                ack_d = A_ACK1;
                if (win_vld) begin
                    lvl_d          = win_lvl;
                    spur_d         = 1'b0;
                    isr_d[win_lvl] = 1'b1;
                    // Acknowledge beats a simultaneous new edge on the same bit.
                    irr_d[win_lvl] = 1'b0;
                end else begin
                    lvl_d  = 3'(SPURIOUS_LVL);
                    spur_d = 1'b1;
                end
            end
            A_ACK1: if (inta_fall) ack_d = A_ACK2;
            A_ACK2: if (inta_rise) begin
                ack_d = A_IDLE;
                // A spurious cycle never set ISR, so AEOI must not clear a real bit.
                if (aeoi_q && !spur_q) isr_d[lvl_q] = 1'b0;
            end
            default: ack_d = A_IDLE;
        endcase

        if (is_icw1) begin
            imr_d = 8'h00;
            isr_d = 8'h00;
            irr_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= S_UNINIT;
            ack_q       <= A_IDLE;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            imr_q       <= 8'h00;
            base_q      <= 5'd0;
            aeoi_q      <= 1'b0;
            rsel_q      <= 1'b0;
            need_icw4_q <= 1'b0;
            lvl_q       <= 3'd0;
            spur_q      <= 1'b0;
            wr_q        <= 1'b1;
            inta_q      <= 1'b1;
            ir_q        <= 8'h00;
            intr_q      <= 1'b0;
        end else begin
            init_q      <= init_d;
            ack_q       <= ack_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            base_q      <= base_d;
            aeoi_q      <= aeoi_d;
            rsel_q      <= rsel_d;
            need_icw4_q <= need_icw4_d;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
            wr_q        <= bus.wr_n;
            inta_q      <= bus.inta_n;
            ir_q        <= bus.ir;
            intr_q      <= intr_d;
        end
    end

    // Gate with the current init state so a fresh ICW1 drops intr immediately.
    assign bus.intr = intr_q & (init_q == S_READY);

    assign vec_out     = (ack_q == A_ACK2) & ~bus.inta_n;
    assign rd_out      = ~bus.cs_n & ~bus.rd_n;
    assign bus.dout_en = vec_out | rd_out;
    assign bus.dout    = vec_out ? {base_q, lvl_q} :
                         rd_out  ? (bus.a0 ? imr_q : (rsel_q ? isr_q : irr_q)) :
                                   8'h00;

endmodule
